// File: rtl/qam_demap_pkg.sv
// Shared constants for the QAM slicer and demapper: Gray codes, bits per symbol
// and the default 16-QAM decision threshold.
package qam_demap_pkg;

    localparam logic [1:0] G_OUTER_POS = 2'b10;
    localparam logic [1:0] G_INNER_POS = 2'b11;
    localparam logic [1:0] G_INNER_NEG = 2'b01;
    localparam logic [1:0] G_OUTER_NEG = 2'b00;

    localparam int BPS_QPSK    = 2;
    localparam int BPS_16      = 4;
    localparam int THR_DEFAULT = 32;

    typedef enum logic {
        MODE_QPSK  = 1'b0,
        MODE_QAM16 = 1'b1
    } mode_e;

endpackage

// File: rtl/qam_axis_slicer.sv
// Combinational hard decision for one signed axis: 2-bit Gray code and sign.
// Zero counts as positive; +THR is an outer point, -THR an inner one.
module qam_axis_slicer
    import qam_demap_pkg::*;
#(
    parameter int IQ_W = 8,
    parameter int THR  = THR_DEFAULT
) (
    input  logic signed [IQ_W-1:0] x,
    output logic [1:0]             gray,
    output logic                   pos
);

    localparam logic signed [IQ_W-1:0] THR_P = IQ_W'(THR);
    localparam logic signed [IQ_W-1:0] THR_N = IQ_W'(-THR);

    // Threshold decision on the signed sample
    always_comb begin
        gray = G_OUTER_NEG;
        pos  = ~x[IQ_W-1];
        if (x >= THR_P) begin
            gray = G_OUTER_POS;
        end else if (!x[IQ_W-1]) begin
            gray = G_INNER_POS;
        end else if (x >= THR_N) begin
            gray = G_INNER_NEG;
        end else begin
            gray = G_OUTER_NEG;
        end
    end

endmodule

// File: rtl/qam_symbol_slicer.sv
// Hard-decision QAM slicer: slice stage, MSB-first bit packer, FIFO write
// stage with drop accounting and saturating symbol/drop counters.
module qam_symbol_slicer
    import qam_demap_pkg::*;
#(
    parameter int IQ_W  = 8,
    parameter int THR   = THR_DEFAULT,
    parameter int OUT_W = 8,
    parameter int CNT_W = 16
) (
    input  logic                   dclk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   qam16,
    input  logic                   in_valid,
    input  logic signed [IQ_W-1:0] in_i,
    input  logic signed [IQ_W-1:0] in_q,
    input  logic                   write_enable,
    input  logic                   wfull,
    output logic [OUT_W-1:0]       wdata,
    output logic                   winc,
    output logic                   busy,
    output logic [CNT_W-1:0]       sym_count,
    output logic [CNT_W-1:0]       drop_count
);

    localparam int SPW_16   = OUT_W / BPS_16;
    localparam int SPW_QPSK = OUT_W / BPS_QPSK;
    localparam int IDX_W    = $clog2(SPW_QPSK + 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic [1:0]       gray_i_s, gray_q_s;
    logic             pos_i_s, pos_q_s;
    logic             accept_s, write_ok_s;
    logic             slice_valid_r;
    logic [3:0]       slice_sym_r;
    mode_e            slice_mode_r, pack_mode_r, mode_n_s;
    logic [IDX_W-1:0] idx_r, idx_n_s, cnt_base_s, cnt_inc_s, spw_s;
    logic [OUT_W-1:0] shift_r, shift_n_s, base_s, shifted_s;
    logic             done_s, word_valid_r;
    logic [OUT_W-1:0] word_r, wdata_r;
    logic             winc_r;
    logic [CNT_W-1:0] sym_cnt_r, drop_cnt_r;

    qam_axis_slicer #(.IQ_W(IQ_W), .THR(THR)) u_slice_i (.x(in_i), .gray(gray_i_s), .pos(pos_i_s));
    qam_axis_slicer #(.IQ_W(IQ_W), .THR(THR)) u_slice_q (.x(in_q), .gray(gray_q_s), .pos(pos_q_s));

    assign accept_s   = in_valid & enable;
    assign write_ok_s = write_enable & ~wfull;

    // Slice stage: register the symbol bits together with the mode they were sliced in
    always_ff @(posedge dclk or posedge reset) begin
        if (reset) begin
            slice_valid_r <= 1'b0;
            slice_sym_r   <= 4'b0000;
            slice_mode_r  <= MODE_QPSK;
        end else begin
            slice_valid_r <= accept_s;
            if (accept_s) begin
                slice_mode_r <= mode_e'(qam16);
                slice_sym_r  <= qam16 ? {gray_i_s, gray_q_s} : {2'b00, pos_i_s, pos_q_s};
            end else begin
                slice_mode_r <= slice_mode_r;
                slice_sym_r  <= slice_sym_r;
            end
        end
    end

    // Packer: a symbol in a different mode than the pending word restarts the word
    always_comb begin
        idx_n_s    = idx_r;
        shift_n_s  = shift_r;
        mode_n_s   = pack_mode_r;
        done_s     = 1'b0;
        base_s     = shift_r;
        cnt_base_s = idx_r;
        shifted_s  = shift_r;
        cnt_inc_s  = idx_r;
        spw_s      = (slice_mode_r == MODE_QAM16) ? IDX_W'(SPW_16) : IDX_W'(SPW_QPSK);
        if (!enable) begin
            idx_n_s = {IDX_W{1'b0}};
        end else if (slice_valid_r) begin
            if ((idx_r == {IDX_W{1'b0}}) || (slice_mode_r != pack_mode_r)) begin
                mode_n_s   = slice_mode_r;
                base_s     = {OUT_W{1'b0}};
                cnt_base_s = {IDX_W{1'b0}};
            end else begin
                base_s     = shift_r;
                cnt_base_s = idx_r;
            end
            shifted_s = (slice_mode_r == MODE_QAM16) ? ((base_s << BPS_16) | OUT_W'(slice_sym_r))
                                                     : ((base_s << BPS_QPSK) | OUT_W'(slice_sym_r[1:0]));
            cnt_inc_s = cnt_base_s + IDX_W'(1);
            if (cnt_inc_s == spw_s) begin
                done_s  = 1'b1;
                idx_n_s = {IDX_W{1'b0}};
            end else begin
                idx_n_s   = cnt_inc_s;
                shift_n_s = shifted_s;
            end
        end else if ((idx_r != {IDX_W{1'b0}}) && (mode_e'(qam16) != pack_mode_r)) begin
            idx_n_s = {IDX_W{1'b0}};
        end else begin
            idx_n_s = idx_r;
        end
    end

    // Pack state and the completed-word register feeding the write stage
    always_ff @(posedge dclk or posedge reset) begin
        if (reset) begin
            idx_r        <= {IDX_W{1'b0}};
            shift_r      <= {OUT_W{1'b0}};
            pack_mode_r  <= MODE_QPSK;
            word_valid_r <= 1'b0;
            word_r       <= {OUT_W{1'b0}};
        end else begin
            idx_r        <= idx_n_s;
            shift_r      <= shift_n_s;
            pack_mode_r  <= mode_n_s;
            word_valid_r <= done_s;
            word_r       <= done_s ? shifted_s : word_r;
        end
    end

    // Write stage: a completed word is written or dropped, never delayed
    always_ff @(posedge dclk or posedge reset) begin
        if (reset) begin
            winc_r     <= 1'b0;
            wdata_r    <= {OUT_W{1'b0}};
            drop_cnt_r <= {CNT_W{1'b0}};
        end else begin
            winc_r <= word_valid_r & write_ok_s;
            if (word_valid_r && write_ok_s) begin
                wdata_r    <= word_r;
                drop_cnt_r <= drop_cnt_r;
            end else if (word_valid_r) begin
                wdata_r    <= wdata_r;
                drop_cnt_r <= sat_inc(drop_cnt_r);
            end else begin
                wdata_r    <= wdata_r;
                drop_cnt_r <= drop_cnt_r;
            end
        end
    end

    // Accepted-symbol counter
    always_ff @(posedge dclk or posedge reset) begin
        if (reset) begin
            sym_cnt_r <= {CNT_W{1'b0}};
        end else begin
            sym_cnt_r <= accept_s ? sat_inc(sym_cnt_r) : sym_cnt_r;
        end
    end

    assign wdata      = wdata_r;
    assign winc       = winc_r;
    assign sym_count  = sym_cnt_r;
    assign drop_count = drop_cnt_r;
    assign busy       = slice_valid_r | (idx_r != {IDX_W{1'b0}});

endmodule
